access_lockout_controller: RTL and testbench
============================================

Name: access_lockout_controller

Overview:
Session controller that sits above the password checker. It drives the checker's StartValidation enable and watches the checker's pass, wrong-pass and timeout flags. It counts failed attempts and enforces a timed lockout after MaxAttempts consecutive failures. It also holds a timed unlock grant after a correct entry.

Parameters:
MaxAttempts, 3, consecutive failures allowed before lockout (1..7)
LockSeconds, 30, lockout duration in Tick pulses (1..2^CntWidth-1)
GrantSeconds, 5, unlock-grant duration in Tick pulses (1..2^CntWidth-1)
CntWidth, 6, width of the shared countdown counter

Ports:
Clk  input  1  system clock (50 MHz board clock)
ResetN  input  1  asynchronous active-low reset
Tick  input  1  one-Clk-cycle pulse per second, from the clock divider, synchronous to Clk
StartReq  input  1  debounced one-cycle request to begin an entry session
CancelReq  input  1  debounced one-cycle request to abandon the current session
PassOk  input  1  checker CurrPass flag (level, asynchronous to Clk)
PassFail  input  1  checker WrongPass flag (level, asynchronous to Clk)
PassTimeOut  input  1  checker TimeOut flag (level, asynchronous to Clk)
StartValidation  output  1  enable to the checker, high only in CHECK
Unlocked  output  1  high in GRANTED
LockedOut  output  1  high in LOCKOUT
AttemptsLeft  output  3  remaining attempts before lockout
Remaining  output  CntWidth  seconds left in GRANTED/LOCKOUT, 0 otherwise
State  output  3  FSM state code, for display/debug

Behaviour:
- Reset (ResetN low, asynchronous): state IDLE, all 1-bit outputs 0, AttemptsLeft=MaxAttempts, Remaining=0, synchroniser flops 0.
- PassOk/PassFail/PassTimeOut each pass through a 2-FF synchroniser and then a rising-edge detector (prev flop).
  - A rising input is acted on at the 3rd Clk edge after it goes high.
  - Levels that are held high do not retrigger.
- State encodings: IDLE=0, CHECK=1, GRANTED=2, FAILED=3, LOCKOUT=4. All outputs are registered.
- IDLE: StartReq -> CHECK. CancelReq and result edges are ignored.
- CHECK: StartValidation=1. Priority, highest first:
  - fail edge (PassFail or PassTimeOut) -> FAILED;
  - PassOk edge -> GRANTED, load Remaining=GrantSeconds, AttemptsLeft=MaxAttempts;
  - CancelReq -> IDLE, no attempt consumed.
  - StartReq is ignored.
- FAILED (exactly 1 cycle, StartValidation=0):
  - AttemptsLeft decrements by 1.
  - If the decremented value is 0 -> LOCKOUT with Remaining=LockSeconds; else -> IDLE.
- GRANTED: Unlocked=1.
  - Each Tick decrements Remaining.
  - On a Tick with Remaining==1 -> Remaining=0, go to IDLE.
  - StartReq and CancelReq are ignored.
- LOCKOUT: LockedOut=1. StartReq and CancelReq are ignored. Remaining counts down on Tick as in GRANTED.
  - On the final tick -> IDLE with AttemptsLeft=MaxAttempts.
- Tick arriving in the same cycle as GRANTED/LOCKOUT entry is not counted; counting starts with the next Tick.
- Remaining never wraps below 0. It is forced to 0 in IDLE, CHECK and FAILED.
- Illegal state codes 5-7 -> IDLE next cycle with AttemptsLeft unchanged.
- Reset asserted mid-session drops StartValidation immediately (asynchronously). The checker then clears its own flags.

Decomposition:
- Shared package: state encodings (IDLE..LOCKOUT) and the 3-bit state width, so the checker and display modules can decode State.
- One sub-module is natural: sync_edge_detect (2-FF synchroniser plus rising-edge pulse, with asynchronous active-low reset). It is instantiated three times.

Test Plan:
- Reset, then StartReq, then PassOk high -> StartValidation=1 at the 1st edge after StartReq. Unlocked=1 at the 3rd edge after PassOk rises, Remaining=5. After 5 Ticks: Unlocked=0, state IDLE, AttemptsLeft=3.
- Three sessions each ending with PassFail -> AttemptsLeft goes 2, 1, then LockedOut=1 with Remaining=30. StartReq during lockout gives no response. After 30 Ticks: IDLE, AttemptsLeft=3.
- PassFail and PassOk rising in the same cycle during CHECK -> FAILED taken, AttemptsLeft=2, Unlocked stays 0.
- CHECK then CancelReq -> IDLE, StartValidation=0, AttemptsLeft unchanged at 3. PassTimeOut rising in a later CHECK -> counted as a failure.
- PassFail held high across two sessions -> only one decrement, because the detector is edge-based.
- ResetN pulsed low mid-LOCKOUT with Remaining=12 -> all outputs at reset values immediately, AttemptsLeft=3.

Source files
------------

// File: rtl/access_lockout_controller_pkg.sv
// Shared definitions for the access lockout controller.
// Checker and display logic decode State using these same encodings.
package access_lockout_controller_pkg;

    localparam int StateWidth = 3;

    typedef enum logic [StateWidth-1:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        GRANTED = 3'd2,
        FAILED  = 3'd3,
        LOCKOUT = 3'd4
    } lockState_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge detector.
// The output pulse lasts one Clk cycle and goes high two edges after the input rises.
module sync_edge_detect (
    input  logic Clk,
    input  logic ResetN,
    input  logic AsyncIn,
    output logic RisePulse
);

    logic syncMeta;
    logic syncStable;
    logic prevLevel;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            syncMeta   <= 1'b0;
            syncStable <= 1'b0;
            prevLevel  <= 1'b0;
        end else begin
            syncMeta   <= AsyncIn;
            syncStable <= syncMeta;
            prevLevel  <= syncStable;
        end
    end

    assign RisePulse = syncStable & ~prevLevel;

endmodule

// File: rtl/access_lockout_controller.sv
// Session controller above the password checker: counts failed attempts,
// enforces a timed lockout, and holds a timed unlock grant.
module access_lockout_controller
    import access_lockout_controller_pkg::*;
#(
    parameter int MaxAttempts  = 3,
    parameter int LockSeconds  = 30,
    parameter int GrantSeconds = 5,
    parameter int CntWidth     = 6
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  Tick,
    input  logic                  StartReq,
    input  logic                  CancelReq,
    input  logic                  PassOk,
    input  logic                  PassFail,
    input  logic                  PassTimeOut,
    output logic                  StartValidation,
    output logic                  Unlocked,
    output logic                  LockedOut,
    output logic [2:0]            AttemptsLeft,
    output logic [CntWidth-1:0]   Remaining,
    output logic [StateWidth-1:0] State
);

    localparam logic [2:0]          MaxAttemptsVal = 3'(MaxAttempts);
    localparam logic [CntWidth-1:0] LockLoad       = CntWidth'(LockSeconds);
    localparam logic [CntWidth-1:0] GrantLoad      = CntWidth'(GrantSeconds);
    localparam logic [CntWidth-1:0] CntOne         = CntWidth'(1);

    lockState_t          state;
    lockState_t          nextState;
    logic [2:0]          attemptsLeft;
    logic [2:0]          nextAttempts;
    logic [CntWidth-1:0] remaining;
    logic [CntWidth-1:0] nextRemaining;
    logic                startValidationReg;
    logic                unlockedReg;
    logic                lockedOutReg;

    logic okEdge;
    logic failEdge;
    logic timeOutEdge;
    logic anyFailEdge;

    sync_edge_detect okDetect (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .AsyncIn   (PassOk),
        .RisePulse (okEdge)
    );

    sync_edge_detect failDetect (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .AsyncIn   (PassFail),
        .RisePulse (failEdge)
    );

    sync_edge_detect timeOutDetect (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .AsyncIn   (PassTimeOut),
        .RisePulse (timeOutEdge)
    );

    assign anyFailEdge = failEdge | timeOutEdge;

    // Outputs are decoded from the next state so they change on the same edge as State.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state              <= IDLE;
            attemptsLeft       <= MaxAttemptsVal;
            remaining          <= '0;
            startValidationReg <= 1'b0;
            unlockedReg        <= 1'b0;
            lockedOutReg       <= 1'b0;
        end else begin
            state              <= nextState;
            attemptsLeft       <= nextAttempts;
            remaining          <= nextRemaining;
            startValidationReg <= (nextState == CHECK);
            unlockedReg        <= (nextState == GRANTED);
            lockedOutReg       <= (nextState == LOCKOUT);
        end
    end

    always_comb begin
        nextState     = state;
        nextAttempts  = attemptsLeft;
        nextRemaining = '0;

        case (state)
            IDLE: begin
                if (StartReq) begin
                    nextState = CHECK;
                end
            end

            // A failure wins over a simultaneous pass so a racing checker cannot unlock.
            CHECK: begin
                if (anyFailEdge) begin
                    nextState = FAILED;
                end else if (okEdge) begin
                    nextState     = GRANTED;
                    nextRemaining = GrantLoad;
                    nextAttempts  = MaxAttemptsVal;
                end else if (CancelReq) begin
                    nextState = IDLE;
                end
            end

            FAILED: begin
                if (attemptsLeft <= 3'd1) begin
                    nextAttempts  = 3'd0;
                    nextState     = LOCKOUT;
                    nextRemaining = LockLoad;
                end else begin
                    nextAttempts = attemptsLeft - 3'd1;
                    nextState    = IDLE;
                end
            end

            GRANTED: begin
                nextRemaining = remaining;
                if (Tick) begin
                    if (remaining <= CntOne) begin
                        nextRemaining = '0;
                        nextState     = IDLE;
                    end else begin
                        nextRemaining = remaining - CntOne;
                    end
                end
            end

            LOCKOUT: begin
                nextRemaining = remaining;
                if (Tick) begin
                    if (remaining <= CntOne) begin
                        nextRemaining = '0;
                        nextAttempts  = MaxAttemptsVal;
                        nextState     = IDLE;
                    end else begin
                        nextRemaining = remaining - CntOne;
                    end
                end
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign StartValidation = startValidationReg;
    assign Unlocked        = unlockedReg;
    assign LockedOut       = lockedOutReg;
    assign AttemptsLeft    = attemptsLeft;
    assign Remaining       = remaining;
    assign State           = state;

endmodule

// File: tb/tb_access_lockout_controller.sv
// Directed scoreboard bench for access_lockout_controller (MaxAttempts=3, Lock=30, Grant=5).
// Inputs change and outputs are sampled on the falling edge of Clk.
module tb_access_lockout_controller;
    import access_lockout_controller_pkg::*;

    logic       Clk         = 1'b0;
    logic       ResetN      = 1'b0;
    logic       Tick        = 1'b0;
    logic       StartReq    = 1'b0;
    logic       CancelReq   = 1'b0;
    logic       PassOk      = 1'b0;
    logic       PassFail    = 1'b0;
    logic       PassTimeOut = 1'b0;
    logic       StartValidation;
    logic       Unlocked;
    logic       LockedOut;
    logic [2:0] AttemptsLeft;
    logic [5:0] Remaining;
    logic [2:0] State;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        string       tag;
        logic [14:0] value;
    } expect_t;

    expect_t scoreboard[$];

    access_lockout_controller #(
        .MaxAttempts  (3),
        .LockSeconds  (30),
        .GrantSeconds (5),
        .CntWidth     (6)
    ) dut (
        .Clk             (Clk),
        .ResetN          (ResetN),
        .Tick            (Tick),
        .StartReq        (StartReq),
        .CancelReq       (CancelReq),
        .PassOk          (PassOk),
        .PassFail        (PassFail),
        .PassTimeOut     (PassTimeOut),
        .StartValidation (StartValidation),
        .Unlocked        (Unlocked),
        .LockedOut       (LockedOut),
        .AttemptsLeft    (AttemptsLeft),
        .Remaining       (Remaining),
        .State           (State)
    );

    always #5 Clk = ~Clk;

    task automatic applyStimulus(input logic start, input logic cancel, input logic tick);
        StartReq  = start;
        CancelReq = cancel;
        Tick      = tick;
        @(negedge Clk);
        StartReq  = 1'b0;
        CancelReq = 1'b0;
        Tick      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expectOut(input string tag, input logic sv, input logic unl, input logic lo,
                             input logic [2:0] att, input logic [5:0] rem, input logic [2:0] st);
        expect_t e;
        e.tag   = tag;
        e.value = {sv, unl, lo, att, rem, st};
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t     e;
        logic [14:0] observed;
        observed = {StartValidation, Unlocked, LockedOut, AttemptsLeft, Remaining, State};
        checkCount++;
        if (scoreboard.size() == 0) begin
            $display("[TB] FAIL scoreboard-empty observed=%h expected=none", observed);
            return;
        end
        e = scoreboard.pop_front();
        assert (observed === e.value) passCount++;
        else $error("[TB] FAIL %s observed sv=%b unl=%b lo=%b att=%0d rem=%0d st=%0d expected sv=%b unl=%b lo=%b att=%0d rem=%0d st=%0d",
                    e.tag, StartValidation, Unlocked, LockedOut, AttemptsLeft, Remaining, State,
                    e.value[14], e.value[13], e.value[12], e.value[11:9], e.value[8:3], e.value[2:0]);
    endtask

    // One entry session ending in a failure flag; lockout follows when the last attempt is used.
    task automatic runFailure(input string name, input logic [2:0] attBefore,
                              input bit useTimeout, input bit alsoOk);
        expectOut({name, "-check"}, 1'b1, 1'b0, 1'b0, attBefore, 6'd0, CHECK);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput();
        if (useTimeout) PassTimeOut = 1'b1;
        else            PassFail    = 1'b1;
        if (alsoOk)     PassOk      = 1'b1;
        idle(2);
        expectOut({name, "-failed"}, 1'b0, 1'b0, 1'b0, attBefore, 6'd0, FAILED);
        idle(1);
        checkOutput();
        if (attBefore == 3'd1)
            expectOut({name, "-lockout"}, 1'b0, 1'b0, 1'b1, 3'd0, 6'd30, LOCKOUT);
        else
            expectOut({name, "-idle"}, 1'b0, 1'b0, 1'b0, attBefore - 3'd1, 6'd0, IDLE);
        idle(1);
        checkOutput();
        PassFail    = 1'b0;
        PassTimeOut = 1'b0;
        PassOk      = 1'b0;
        idle(3);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        expectOut("reset", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, IDLE);
        checkOutput();
        ResetN = 1'b1;
        expectOut("idle-after-reset", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, IDLE);
        idle(1);
        checkOutput();

        // Successful entry and grant countdown
        expectOut("grant-start", 1'b1, 1'b0, 1'b0, 3'd3, 6'd0, CHECK);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput();
        PassOk = 1'b1;
        expectOut("ok-edge1", 1'b1, 1'b0, 1'b0, 3'd3, 6'd0, CHECK);
        idle(1);
        checkOutput();
        expectOut("ok-edge2", 1'b1, 1'b0, 1'b0, 3'd3, 6'd0, CHECK);
        idle(1);
        checkOutput();
        expectOut("grant-entry-tick-ignored", 1'b0, 1'b1, 1'b0, 3'd3, 6'd5, GRANTED);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput();
        PassOk = 1'b0;
        expectOut("grant-start-cancel-ignored", 1'b0, 1'b1, 1'b0, 3'd3, 6'd5, GRANTED);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput();
        for (int i = 1; i <= 4; i++) begin
            expectOut($sformatf("grant-tick%0d", i), 1'b0, 1'b1, 1'b0, 3'd3, 6'(5 - i), GRANTED);
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput();
        end
        expectOut("grant-expired", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, IDLE);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput();

        // Three failures lead to lockout
        runFailure("fail1", 3'd3, 1'b0, 1'b0);
        runFailure("fail2", 3'd2, 1'b0, 1'b0);
        runFailure("fail3", 3'd1, 1'b0, 1'b0);
        expectOut("lock-start-ignored", 1'b0, 1'b0, 1'b1, 3'd0, 6'd30, LOCKOUT);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput();
        for (int i = 1; i <= 29; i++) begin
            expectOut($sformatf("lock-tick%0d", i), 1'b0, 1'b0, 1'b1, 3'd0, 6'(30 - i), LOCKOUT);
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput();
        end
        expectOut("lock-expired", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, IDLE);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput();

        // Cancel consumes no attempt; timeout counts as failure; fail beats simultaneous pass
        expectOut("cancel-check", 1'b1, 1'b0, 1'b0, 3'd3, 6'd0, CHECK);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput();
        expectOut("cancel-idle", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, IDLE);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput();
        runFailure("timeout", 3'd3, 1'b1, 1'b0);
        runFailure("simultaneous", 3'd2, 1'b0, 1'b1);

        ResetN = 1'b0;
        expectOut("reset-pulse", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, IDLE);
        idle(1);
        checkOutput();
        ResetN = 1'b1;
        idle(1);

        // Held PassFail must not retrigger in the following session
        expectOut("held-check1", 1'b1, 1'b0, 1'b0, 3'd3, 6'd0, CHECK);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput();
        PassFail = 1'b1;
        idle(2);
        expectOut("held-failed", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, FAILED);
        idle(1);
        checkOutput();
        expectOut("held-idle", 1'b0, 1'b0, 1'b0, 3'd2, 6'd0, IDLE);
        idle(1);
        checkOutput();
        expectOut("held-check2", 1'b1, 1'b0, 1'b0, 3'd2, 6'd0, CHECK);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput();
        expectOut("held-no-retrigger", 1'b1, 1'b0, 1'b0, 3'd2, 6'd0, CHECK);
        idle(4);
        checkOutput();
        expectOut("held-cancel", 1'b0, 1'b0, 1'b0, 3'd2, 6'd0, IDLE);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput();
        PassFail = 1'b0;
        idle(3);

        // Asynchronous reset in the middle of a lockout
        runFailure("prelock1", 3'd2, 1'b0, 1'b0);
        runFailure("prelock2", 3'd1, 1'b0, 1'b0);
        expectOut("lock-rem12", 1'b0, 1'b0, 1'b1, 3'd0, 6'd12, LOCKOUT);
        repeat (18) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput();
        #2;
        ResetN = 1'b0;
        #1;
        expectOut("async-reset-mid-lockout", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, IDLE);
        checkOutput();
        @(negedge Clk);
        ResetN = 1'b1;
        expectOut("after-async-reset", 1'b0, 1'b0, 1'b0, 3'd3, 6'd0, IDLE);
        idle(1);
        checkOutput();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
